// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: LSU-side request/response bundle between the core and sram_ctrl
interface sram_ctrl_if;
  logic [18:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_bmask;
  logic        i_rden;
  logic        i_wren;
  logic [31:0] o_rdata;
  logic        o_ack;
  logic        o_busy;
  modport master (output i_addr, i_wdata, i_bmask, i_rden, i_wren, input o_rdata, o_ack, o_busy);
  modport slave (input i_addr, i_wdata, i_bmask, i_rden, i_wren, output o_rdata, o_ack, o_busy);
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: splits 32-bit LSU accesses into two 16-bit async SRAM accesses
module sram_ctrl #(
  parameter int P_WAIT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sram_ctrl_if.slave  lsu,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_LO = 3'd1;
  localparam logic [2:0] RD_HI = 3'd2;
  localparam logic [2:0] WR_LO = 3'd3;
  localparam logic [2:0] WR_HI = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] LAST  = 3'(P_WAIT);
  logic [2:0]  state_q, state_d, cnt_q, cnt_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  bmask_q, bmask_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dq_q, dq_d, dq_in;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic        lb_n_q, lb_n_d, ub_n_q, ub_n_d, dq_oe_q, dq_oe_d;
  logic        last, rd, wr, lo, hi;
  logic        unused_addr_lsbs;
  assign dq_in = SRAM_DQ;
  assign last = cnt_q == LAST;
  assign unused_addr_lsbs = ^lsu.i_addr[1:0];
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    word_d  = state_q == IDLE ? lsu.i_addr[18:2] : word_q;
    wdata_d = state_q == IDLE ? lsu.i_wdata : wdata_q;
    bmask_d = state_q == IDLE ? lsu.i_bmask : bmask_q;
    case (state_q)
      IDLE:    state_d = lsu.i_wren ? (|lsu.i_bmask[1:0] ? WR_LO : |lsu.i_bmask[3:2] ? WR_HI : DONE)
                       : lsu.i_rden ? RD_LO : IDLE;
      RD_LO: if (last) begin
        rdata_d[15:0] = dq_in;
        state_d = RD_HI;
      end
      RD_HI: if (last) begin
        rdata_d[31:16] = dq_in;
        state_d = DONE;
      end
      WR_LO:   state_d = last ? (|bmask_q[3:2] ? WR_HI : DONE) : WR_LO;
      WR_HI:   state_d = last ? DONE : WR_HI;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d != state_q ? 3'd0 : cnt_q + 3'd1;
  end
  // SRAM pins are computed from the next state so the flops present them glitch-free in that state
  always_comb begin
    rd      = state_d == RD_LO || state_d == RD_HI;
    wr      = state_d == WR_LO || state_d == WR_HI;
    lo      = state_d == RD_LO || state_d == WR_LO;
    hi      = state_d == RD_HI || state_d == WR_HI;
    addr_d  = lo ? {word_d, 1'b0} : hi ? {word_d, 1'b1} : addr_q;
    ce_n_d  = !(rd || wr);
    oe_n_d  = !rd;
    we_n_d  = !(wr && cnt_d != LAST);
    lb_n_d  = rd ? 1'b0 : state_d == WR_LO ? ~bmask_d[0] : state_d == WR_HI ? ~bmask_d[2] : 1'b1;
    ub_n_d  = rd ? 1'b0 : state_d == WR_LO ? ~bmask_d[1] : state_d == WR_HI ? ~bmask_d[3] : 1'b1;
    dq_d    = state_d == WR_HI ? wdata_d[31:16] : wdata_d[15:0];
    dq_oe_d = wr;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      lb_n_q  <= lb_n_d;
      ub_n_q  <= ub_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end
  assign SRAM_DQ     = dq_oe_q ? dq_q : 16'hzzzz;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_LB_N   = lb_n_q;
  assign SRAM_UB_N   = ub_n_q;
  assign lsu.o_rdata = rdata_q;
  assign lsu.o_ack   = state_q == DONE;
  assign lsu.o_busy  = state_q != IDLE;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: table vectors, corner sequences and random traffic against a word-level memory model
module tb_sram_ctrl;
  localparam int P = 1;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] cur_rd = '0;
  logic [15:0] mem [0:262143] = '{default: 16'h0};
  logic [31:0] ref_mem [0:131071] = '{default: 32'h0};
  sram_ctrl_if bus ();
  sram_ctrl #(.P_WAIT(P)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .lsu(bus), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
  );
  always #5 clk = ~clk;
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (!ce_n && !we_n && !lb_n) mem[sram_addr][7:0] <= sram_dq[7:0];
    if (!ce_n && !we_n && !ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic int n_phases(input logic wr, input logic [3:0] bm);
    return wr ? int'(|bm[1:0]) + int'(|bm[3:2]) : 2;
  endfunction
  function automatic void ref_write(input logic [18:0] a, input logic [31:0] wd, input logic [3:0] bm);
    for (int b = 0; b < 4; b++)
      if (bm[b]) ref_mem[a[18:2]][8*b +: 8] = wd[8*b +: 8];
  endfunction
  task automatic txn(input logic wr, input logic rd, input logic [18:0] a, input logic [31:0] wd,
                     input logic [3:0] bm, input int exp_ack, input logic [31:0] exp_rd);
    int ack_at, ce_lo, we_lo, bus_err, ph;
    logic lo;
    ph = n_phases(wr, bm);
    ack_at = -1; ce_lo = 0; we_lo = 0; bus_err = 0;
    @(negedge clk);
    chk("idle_ack", {31'b0, bus.o_ack}, 32'd0);
    chk("idle_busy", {31'b0, bus.o_busy}, 32'd0);
    bus.i_wren = wr; bus.i_rden = rd; bus.i_addr = a; bus.i_wdata = wd; bus.i_bmask = bm;
    for (int c = 1; c <= 40 && ack_at < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.i_addr = ~a; bus.i_wdata = ~wd; bus.i_bmask = ~bm;
      end
      if (!ce_n) begin
        ce_lo++;
        lo = !sram_addr[0];
        if (sram_addr[17:1] != a[18:2]) bus_err++;
        if (wr && (!oe_n || lb_n != ~(lo ? bm[0] : bm[2]) || ub_n != ~(lo ? bm[1] : bm[3]))) bus_err++;
        if (!wr && (oe_n || !we_n || lb_n || ub_n)) bus_err++;
      end
      if (!we_n) we_lo++;
      if (bus.o_ack) ack_at = c;
    end
    bus.i_wren = 1'b0; bus.i_rden = 1'b0;
    chk("ack_cycle", ack_at, exp_ack);
    chk("ce_low_cycles", ce_lo, ph * (P + 1));
    chk("we_low_cycles", we_lo, wr ? ph * P : 0);
    chk("bus_pins", bus_err, 0);
    chk("rdata", bus.o_rdata, exp_rd);
  endtask
  typedef struct {
    logic        wr;
    logic        rd;
    logic [18:0] a;
    logic [31:0] wd;
    logic [3:0]  bm;
    int          ack;
    logic [31:0] rdv;
  } vec_t;
  vec_t tbl [12];
  initial begin
    tbl[0]  = '{1'b1, 1'b0, 19'h00104, 32'hDEADBEEF, 4'b1111, 5, 32'h00000000};
    tbl[1]  = '{1'b0, 1'b1, 19'h00104, 32'h0,        4'b0000, 5, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b0, 19'h00000, 32'h00AB0000, 4'b0100, 3, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 1'b1, 19'h00000, 32'h0,        4'b0000, 5, 32'h00AB0000};
    tbl[4]  = '{1'b1, 1'b0, 19'h00010, 32'hFFFFFFFF, 4'b0000, 1, 32'h00AB0000};
    tbl[5]  = '{1'b1, 1'b1, 19'h00108, 32'h12345678, 4'b1111, 5, 32'h00AB0000};
    tbl[6]  = '{1'b0, 1'b1, 19'h00108, 32'h0,        4'b0000, 5, 32'h12345678};
    tbl[7]  = '{1'b1, 1'b0, 19'h0010A, 32'h55660000, 4'b1100, 3, 32'h12345678};
    tbl[8]  = '{1'b0, 1'b1, 19'h0010B, 32'h0,        4'b0000, 5, 32'h55665678};
    tbl[9]  = '{1'b1, 1'b0, 19'h00104, 32'h00001111, 4'b0011, 3, 32'h55665678};
    tbl[10] = '{1'b0, 1'b1, 19'h00104, 32'h0,        4'b0000, 5, 32'hDEAD1111};
    tbl[11] = '{1'b0, 1'b1, 19'h00010, 32'h0,        4'b0000, 5, 32'h00000000};
    bus.i_wren = 1'b0; bus.i_rden = 1'b0; bus.i_addr = '0; bus.i_wdata = '0; bus.i_bmask = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pins_n", {27'b0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    chk("rst_ack_busy", {30'b0, bus.o_ack, bus.o_busy}, 32'd0);
    chk("rst_rdata", bus.o_rdata, 32'd0);
    chk("rst_addr", {14'b0, sram_addr}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].bm, tbl[i].ack, tbl[i].rdv);
      if (tbl[i].wr) ref_write(tbl[i].a, tbl[i].wd, tbl[i].bm);
      cur_rd = tbl[i].rdv;
      if (i == 0) begin
        chk("mem_0x82", {16'b0, mem[18'h00082]}, 32'h0000BEEF);
        chk("mem_0x83", {16'b0, mem[18'h00083]}, 32'h0000DEAD);
      end
    end
    // reset while the low half of a write is in flight
    @(negedge clk);
    bus.i_wren = 1'b1; bus.i_addr = 19'h00200; bus.i_wdata = 32'hAAAA5555; bus.i_bmask = 4'hF;
    @(negedge clk);
    chk("wr_lo_we_ce", {30'b0, we_n, ce_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_pins_n", {27'b0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    chk("abort_busy", {31'b0, bus.o_busy}, 32'd0);
    bus.i_wren = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_ack", {31'b0, bus.o_ack}, 32'd0);
    end
    rst_n = 1'b1;
    cur_rd = '0;
    chk("abort_rdata", bus.o_rdata, 32'd0);
    txn(1'b1, 1'b0, 19'h00200, 32'hCAFEF00D, 4'hF, 5, cur_rd);
    ref_write(19'h00200, 32'hCAFEF00D, 4'hF);
    txn(1'b0, 1'b1, 19'h00200, 32'h0, 4'h0, 5, 32'hCAFEF00D);
    cur_rd = 32'hCAFEF00D;
    for (int n = 0; n < 80; n++) begin
      logic wr, rd;
      logic [18:0] a;
      logic [31:0] wd;
      logic [3:0] bm;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = n[0] ? 19'($urandom_range(0, 127)) : 19'($urandom);
      wd = $urandom;
      bm = 4'($urandom);
      if (!wr) cur_rd = ref_mem[a[18:2]];
      txn(wr, rd, a, wd, bm, 1 + n_phases(wr, bm) * (P + 1), cur_rd);
      if (wr) ref_write(a, wd, bm);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
